// File: rtl/nco_pkg.sv
// NCO shared widths, reset constants and the quarter-wave sine table.
// Imported by the phase accumulator top and the sine lookup.
package nco_pkg;

   localparam int ACC_W   = 32;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 8;
   localparam int QTR_LEN = 65;
   localparam int QTR_W   = 7;

   localparam logic [DATA_W-1:0] MIDSCALE = 8'd128;

   // round(127*sin(2*pi*j/256)) for j = 0..64
   localparam logic [QTR_W-1:0] QTR_TAB [QTR_LEN] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
      7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
      7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
      7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
      7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
      7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
      7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
      7'd127
   };

   function automatic logic [QTR_W-1:0] qtr_at(input logic [QTR_W-1:0] idx);
      return QTR_TAB[idx];
   endfunction

endpackage

// File: rtl/nco_sine_lut.sv
// Combinational sine lookup: folds an 8-bit phase into the quarter
// table and rebuilds the offset-binary sample around midscale.
module nco_sine_lut
   import nco_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] sample
);

   logic [QTR_W-1:0] low;
   logic [QTR_W-1:0] idx;
   logic [QTR_W-1:0] mag;

   always_comb begin
      low = addr[QTR_W-1:0];
      idx = low;
      // second half of each half-wave mirrors around 64
      if (low > 7'd64) begin
         idx = 7'(8'd128 - {1'b0, low});
      end
      mag = qtr_at(idx);
      if (addr[ADDR_W-1]) begin
         sample = MIDSCALE - {1'b0, mag};
      end else begin
         sample = MIDSCALE + {1'b0, mag};
      end
   end

endmodule

// File: rtl/nco.sv
// Numerically controlled oscillator: 32-bit phase accumulator driving
// a sine LUT, registered 8-bit DAC sample and inverted DAC clock.
module nco
   import nco_pkg::*;
#(
   parameter logic [ACC_W-1:0]  FREQ_WORD    = 32'd85899346,
   parameter logic [ADDR_W-1:0] PHASE_OFFSET = 8'd0
)(
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   output logic [DATA_W-1:0] da_data,
   output logic              da_clk
);

   logic [ACC_W-1:0]  acc_q;
   logic [ACC_W-1:0]  acc_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] sine;

   always_comb begin
      acc_d  = acc_q + FREQ_WORD;
      addr   = acc_q[ACC_W-1 -: ADDR_W] + PHASE_OFFSET;
      data_d = sine;
   end

   nco_sine_lut u_lut (
      .addr   (addr),
      .sample (sine)
   );

   // sys_rst_n is active-high despite its name
   always_ff @(posedge sys_clk or posedge sys_rst_n) begin
      if (sys_rst_n) begin
         acc_q  <= '0;
         data_q <= MIDSCALE;
      end else begin
         acc_q  <= acc_d;
         data_q <= data_d;
      end
   end

   assign da_data = data_q;
   assign da_clk  = ~sys_clk;

endmodule

// File: tb/tb_nco.sv
// Self-checking bench for nco: four parameterisations in parallel,
// scoreboard of model samples, plus an exhaustive sine LUT sweep.
module tb_nco;
   import nco_pkg::*;

   typedef logic [3:0][7:0] smp_t;

   localparam logic [31:0] FW [4] = '{32'h0100_0000, 32'h0100_0000,
                                      32'd85899346, 32'd0};
   localparam logic [7:0] OFF [4] = '{8'd0, 8'd64, 8'd0, 8'd10};
   localparam int KEY_N [6] = '{1, 17, 33, 65, 129, 193};
   localparam int KEY_V [6] = '{128, 177, 218, 255, 128, 1};

   logic       sys_clk = 1'b0;
   logic       rst     = 1'b1;
   logic [7:0] da_a, da_b, da_c, da_z;
   logic       dclk_a, dclk_b, dclk_c, dclk_z;
   logic [7:0] lut_addr = '0;
   logic [7:0] lut_sample;

   int   n_checks = 0;
   int   n_fail   = 0;
   smp_t sb [$];
   logic [31:0] m_acc [4];
   logic [7:0]  hist_a [1:700];
   logic [7:0]  hist_b [1:700];
   int   crossings;
   logic [7:0] prev_c;

   always #10 sys_clk = ~sys_clk;

   nco #(.FREQ_WORD(32'h0100_0000), .PHASE_OFFSET(8'd0)) dut_a (
      .sys_clk(sys_clk), .sys_rst_n(rst), .da_data(da_a), .da_clk(dclk_a));
   nco #(.FREQ_WORD(32'h0100_0000), .PHASE_OFFSET(8'd64)) dut_b (
      .sys_clk(sys_clk), .sys_rst_n(rst), .da_data(da_b), .da_clk(dclk_b));
   nco dut_c (
      .sys_clk(sys_clk), .sys_rst_n(rst), .da_data(da_c), .da_clk(dclk_c));
   nco #(.FREQ_WORD(32'd0), .PHASE_OFFSET(8'd10)) dut_z (
      .sys_clk(sys_clk), .sys_rst_n(rst), .da_data(da_z), .da_clk(dclk_z));

   nco_sine_lut u_lut (.addr(lut_addr), .sample(lut_sample));

   function automatic logic [7:0] sine_ref(input int k);
      real v;
      v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
      return 8'($rtoi(v + 0.5));
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_acc[i] = '0;
      sb.delete();
   endtask

   task automatic model_edge();
      smp_t e;
      logic [7:0] a;
      for (int i = 0; i < 4; i++) begin
         a = m_acc[i][31:24] + OFF[i];
         e[i] = sine_ref(int'(a));
         m_acc[i] = m_acc[i] + FW[i];
      end
      sb.push_back(e);
   endtask

   task automatic check_all_mid(input string tag);
      check({tag, "_a"}, 32'(da_a), 128);
      check({tag, "_b"}, 32'(da_b), 128);
      check({tag, "_c"}, 32'(da_c), 128);
      check({tag, "_z"}, 32'(da_z), 128);
   endtask

   task automatic run_edge(input int n, input bit main_run);
      smp_t e;
      @(posedge sys_clk);
      model_edge();
      @(negedge sys_clk);
      check("sb_size", 32'(sb.size()), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check("data_a", 32'(da_a), 32'(e[0]));
      check("data_b", 32'(da_b), 32'(e[1]));
      check("data_c", 32'(da_c), 32'(e[2]));
      check("data_z", 32'(da_z), 32'(e[3]));
      if (n == 1) begin
         check("first_a", 32'(da_a), 128);
         check("first_b", 32'(da_b), 255);
      end
      if (!main_run) return;
      for (int k = 0; k < 6; k++)
         if (n == KEY_N[k]) check("key_a", 32'(da_a), 32'(KEY_V[k]));
      check("range_c", 32'(da_c >= 8'd1 && da_c <= 8'd255), 1);
      if (prev_c < 8'd128 && da_c >= 8'd128) crossings++;
      prev_c = da_c;
      if (n <= 700) begin
         hist_a[n] = da_a;
         hist_b[n] = da_b;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         @(posedge sys_clk); #1;
         check_all_mid("rst_data");
         check("rst_dclk_hi", 32'(dclk_a), 0);
         @(negedge sys_clk); #1;
         check("rst_dclk_lo", 32'(dclk_c), 1);
      end

      for (int k = 0; k < 256; k++) begin
         lut_addr = 8'(k);
         #1;
         check("lut", 32'(lut_sample), 32'(sine_ref(k)));
      end
      lut_addr = 8'd64;  #1; check("lut_64", 32'(lut_sample), 255);
      lut_addr = 8'd128; #1; check("lut_128", 32'(lut_sample), 128);
      lut_addr = 8'd192; #1; check("lut_192", 32'(lut_sample), 1);

      @(negedge sys_clk);
      rst = 1'b0;
      crossings = 0;
      prev_c = 8'd128;
      for (int n = 1; n <= 5000; n++) run_edge(n, 1'b1);
      check("cycles_c_99_101",
            32'(crossings >= 99 && crossings <= 101), 1);
      for (int n = 257; n <= 700; n++)
         check("period_a", 32'(hist_a[n]), 32'(hist_a[n-256]));
      for (int n = 1; n <= 600; n++)
         check("shift_b", 32'(hist_b[n]), 32'(hist_a[n+64]));

      @(posedge sys_clk);
      #5;
      rst = 1'b1;
      #1;
      check_all_mid("async_rst");
      @(posedge sys_clk); #1;
      check_all_mid("held_rst");
      check("held_dclk", 32'(dclk_b), 0);
      @(negedge sys_clk);
      rst = 1'b0;
      model_reset();
      for (int n = 1; n <= 40; n++) run_edge(n, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
